// File: rtl/snitch_icache_axi_refill.sv
// Instruction-cache refill initiator: each refill request becomes one AXI4 INCR read
// burst; returned beats are assembled into a full line and handed back in order.
package snitch_icache_axi_refill_pkg;

   localparam int unsigned AxiAddrW = 48;
   localparam int unsigned AxiDataW = 64;
   localparam int unsigned AxiIdW   = 4;
   localparam int unsigned AxiUserW = 1;
   localparam int unsigned AxiStrbW = AxiDataW / 8;

   typedef struct packed {
      logic [AxiIdW-1:0]   id;
      logic [AxiAddrW-1:0] addr;
      logic [7:0]          len;
      logic [2:0]          size;
      logic [1:0]          burst;
      logic                lock;
      logic [3:0]          cache;
      logic [2:0]          prot;
      logic [3:0]          qos;
      logic [3:0]          region;
      logic [AxiUserW-1:0] user;
   } refill_axi_ax_t;

   typedef struct packed {
      logic [AxiDataW-1:0] data;
      logic [AxiStrbW-1:0] strb;
      logic                last;
      logic [AxiUserW-1:0] user;
   } refill_axi_w_t;

   typedef struct packed {
      logic [AxiIdW-1:0]   id;
      logic [1:0]          resp;
      logic [AxiUserW-1:0] user;
   } refill_axi_b_t;

   typedef struct packed {
      logic [AxiIdW-1:0]   id;
      logic [AxiDataW-1:0] data;
      logic [1:0]          resp;
      logic                last;
      logic [AxiUserW-1:0] user;
   } refill_axi_r_t;

   typedef struct packed {
      refill_axi_ax_t aw;
      logic           aw_valid;
      refill_axi_w_t  w;
      logic           w_valid;
      logic           b_ready;
      refill_axi_ax_t ar;
      logic           ar_valid;
      logic           r_ready;
   } refill_axi_req_t;

   typedef struct packed {
      logic          aw_ready;
      logic          ar_ready;
      logic          w_ready;
      logic          b_valid;
      refill_axi_b_t b;
      logic          r_valid;
      refill_axi_r_t r;
   } refill_axi_rsp_t;

endpackage

module snitch_icache_axi_refill #(
   parameter int unsigned LineWidth    = 256,
   parameter int unsigned AddrWidth    = 48,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned IdWidth      = 8,
   parameter int unsigned AxiId        = 0,
   parameter int unsigned MaxTrans     = 4,
   parameter type         axi_req_t    = snitch_icache_axi_refill_pkg::refill_axi_req_t,
   parameter type         axi_rsp_t    = snitch_icache_axi_refill_pkg::refill_axi_rsp_t
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [IdWidth-1:0]   req_id_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   output logic [LineWidth-1:0] rsp_data_o,
   output logic                 rsp_error_o,
   output logic [IdWidth-1:0]   rsp_id_o,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output axi_req_t             axi_req_o,
   input  axi_rsp_t             axi_rsp_i,
   output logic                 busy_o
);

   localparam int unsigned Beats   = LineWidth / AxiDataWidth;
   localparam int unsigned CntW    = (Beats > 1) ? $clog2(Beats) : 1;
   localparam int unsigned OffW    = $clog2(LineWidth / 8);
   localparam int unsigned SizeVal = $clog2(AxiDataWidth / 8);
   localparam int unsigned PtrW    = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
   localparam int unsigned FillW   = $clog2(MaxTrans + 1);
   localparam int unsigned ArIdW   = snitch_icache_axi_refill_pkg::AxiIdW;
   localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

   typedef enum logic {
      Collect,
      Full
   } state_e;

   state_e state_q, state_d;

   logic [IdWidth-1:0]   id_mem_q [MaxTrans];
   logic [PtrW-1:0]      wptr_q, rptr_q;
   logic [FillW-1:0]     fill_q;
   logic                 fifo_full, fifo_empty, push, pop;

   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic [LineWidth-1:0] line_q, line_d;
   logic                 r_ready_c, r_hs;
   logic                 unused_rsp;

   assign fifo_full   = (fill_q == FillW'(MaxTrans));
   assign fifo_empty  = (fill_q == '0);
   assign push        = req_valid_i & axi_rsp_i.ar_ready & ~fifo_full;
   assign pop         = (state_q == Full) & rsp_ready_i;
   assign r_hs        = axi_rsp_i.r_valid & r_ready_c;
   assign req_ready_o = axi_rsp_i.ar_ready & ~fifo_full;

   // Read-only master: write channels idle, AR forwarded with zero latency.
   always_comb begin
      axi_req_o          = '0;
      axi_req_o.b_ready  = 1'b1;
      axi_req_o.ar_valid = req_valid_i & ~fifo_full;
      axi_req_o.ar.id    = ArIdW'(AxiId);
      axi_req_o.ar.addr  = {req_addr_i[AddrWidth-1:OffW], OffW'(0)};
      axi_req_o.ar.len   = 8'(Beats - 1);
      axi_req_o.ar.size  = 3'(SizeVal);
      axi_req_o.ar.burst = 2'b01;
      axi_req_o.ar.cache = 4'b0010;
      axi_req_o.r_ready  = r_ready_c;
   end

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // Requester IDs in issue order; a single AXI ID keeps bursts in order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         id_mem_q <= '{default: '0};
         wptr_q   <= '0;
         rptr_q   <= '0;
         fill_q   <= '0;
      end else begin
         if (push) begin
            id_mem_q[wptr_q] <= req_id_i;
            wptr_q           <= ptr_inc(wptr_q);
         end
         if (pop) begin
            rptr_q <= ptr_inc(rptr_q);
         end
         if (push && !pop) begin
            fill_q <= fill_q + FillW'(1);
         end else if (!push && pop) begin
            fill_q <= fill_q - FillW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Collect;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         Collect: if (r_hs && axi_rsp_i.r.last) state_d = Full;
         Full:    if (rsp_ready_i) state_d = Collect;
         default: state_d = Collect;
      endcase
   end

   always_comb begin
      r_ready_c   = 1'b0;
      rsp_valid_o = 1'b0;
      case (state_q)
         Collect: r_ready_c   = ~fifo_empty;
         Full:    rsp_valid_o = 1'b1;
         default: ;
      endcase
   end

   // Beat assembly; a missing last at the final beat flags an error and wraps.
   always_comb begin
      cnt_d  = cnt_q;
      err_d  = err_q;
      line_d = line_q;
      if (pop) begin
         cnt_d = '0;
         err_d = 1'b0;
      end else if (r_hs) begin
         for (int unsigned b = 0; b < Beats; b++) begin
            if (cnt_q == CntW'(b)) begin
               line_d[b*AxiDataWidth +: AxiDataWidth] = axi_rsp_i.r.data;
            end
         end
         err_d = err_q | axi_rsp_i.r.resp[1];
         if (axi_rsp_i.r.last) begin
            if (cnt_q != LastCnt) err_d = 1'b1;
         end else if (cnt_q == LastCnt) begin
            err_d = 1'b1;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         err_q  <= 1'b0;
         line_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         err_q  <= err_d;
         line_q <= line_d;
      end
   end

   assign rsp_data_o  = line_q;
   assign rsp_error_o = err_q;
   assign rsp_id_o    = id_mem_q[rptr_q];
   assign busy_o      = ~fifo_empty;

   assign unused_rsp = ^{req_addr_i[OffW-1:0], axi_rsp_i.aw_ready, axi_rsp_i.w_ready,
                         axi_rsp_i.b_valid, axi_rsp_i.b, axi_rsp_i.r.id,
                         axi_rsp_i.r.resp[0], axi_rsp_i.r.user};

endmodule

// File: tb/tb_snitch_icache_axi_refill.sv
// Bench for snitch_icache_axi_refill: table-driven refills plus hand-written
// backpressure, outstanding-limit, reset and wrap sequences, checked via a scoreboard.
module tb_snitch_icache_axi_refill;

   localparam int unsigned LineWidth = 256;
   localparam int unsigned AddrWidth = 48;
   localparam int unsigned IdWidth   = 8;
   localparam int unsigned CW        = LineWidth;

   logic                 clk = 1'b0;
   logic                 rst_ni = 1'b0;
   logic [AddrWidth-1:0] req_addr;
   logic [IdWidth-1:0]   req_id;
   logic                 req_valid;
   logic                 req_ready;
   logic [LineWidth-1:0] rsp_data;
   logic                 rsp_error;
   logic [IdWidth-1:0]   rsp_id;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic                 busy;
   snitch_icache_axi_refill_pkg::refill_axi_req_t axi_req;
   snitch_icache_axi_refill_pkg::refill_axi_rsp_t axi_rsp;

   always #5 clk = ~clk;

   snitch_icache_axi_refill dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_addr_i  (req_addr),
      .req_id_i    (req_id),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .rsp_data_o  (rsp_data),
      .rsp_error_o (rsp_error),
      .rsp_id_o    (rsp_id),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .axi_req_o   (axi_req),
      .axi_rsp_i   (axi_rsp),
      .busy_o      (busy)
   );

   typedef struct {
      logic [IdWidth-1:0]   id;
      logic [LineWidth-1:0] data;
      logic                 err;
   } exp_t;

   typedef struct {
      logic [AddrWidth-1:0] addr;
      logic [IdWidth-1:0]   id;
      logic [LineWidth-1:0] line;
      logic [7:0]           resp;
      int                   nbeats;
      logic                 err;
   } vec_t;

   exp_t                 sb[$];
   vec_t                 tv[6];
   int                   checks = 0;
   int                   failures = 0;
   logic [LineWidth-1:0] last_line = '0;

   function automatic logic [LineWidth-1:0] mk(input logic [31:0] s);
      logic [LineWidth-1:0] r;
      for (int b = 0; b < 4; b++) r[b*64 +: 64] = {s, 24'hC0FFEE, 8'(b)};
      return r;
   endfunction

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
      end
   endtask

   // Drive a refill request, verify the AR it produces, record the expected line.
   task automatic send_req(input logic [AddrWidth-1:0] addr, input logic [IdWidth-1:0] id,
                           input logic [LineWidth-1:0] line, input logic err);
      int n = 0;
      req_addr = addr;
      req_id = id;
      req_valid = 1'b1;
      axi_rsp.ar_ready = 1'b1;
      #1;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $display("FAIL ar_timeout: req_ready_o=0 after %0d cycles, required 1", n);
      end else begin
         check("ar_valid", CW'(axi_req.ar_valid), CW'(1'b1));
         check("ar_addr", CW'(axi_req.ar.addr), CW'({addr[AddrWidth-1:5], 5'b0}));
         check("ar_len", CW'(axi_req.ar.len), CW'(8'd3));
         check("ar_size", CW'(axi_req.ar.size), CW'(3'd3));
         check("ar_burst", CW'(axi_req.ar.burst), CW'(2'b01));
         check("ar_id_cache", CW'({axi_req.ar.id, axi_req.ar.cache}), CW'({4'd0, 4'b0010}));
         sb.push_back('{id: id, data: line, err: err});
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] data, input logic [1:0] resp, input logic last);
      int n = 0;
      axi_rsp.r_valid = 1'b1;
      axi_rsp.r.data = data;
      axi_rsp.r.resp = resp;
      axi_rsp.r.last = last;
      #1;
      while (!axi_req.r_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!axi_req.r_ready) begin
         checks++;
         failures++;
         $display("FAIL r_timeout: r_ready=0 after %0d cycles, required 1", n);
      end
      @(negedge clk);
      axi_rsp.r_valid = 1'b0;
   endtask

   task automatic take_rsp();
      int n = 0;
      exp_t e;
      #1;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (!rsp_valid) begin
         failures++;
         $display("FAIL rsp_timeout: rsp_valid_o=0 after %0d cycles, required 1", n);
      end else if (sb.size() == 0) begin
         failures++;
         $display("FAIL sb_empty: line id 0x%0h arrived, required none", rsp_id);
      end else begin
         e = sb.pop_front();
         check("rsp_id", CW'(rsp_id), CW'(e.id));
         check("rsp_data", rsp_data, e.data);
         check("rsp_error", CW'(rsp_error), CW'(e.err));
         last_line = e.data;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic full_line(input logic [AddrWidth-1:0] addr, input logic [IdWidth-1:0] id,
                            input logic [LineWidth-1:0] line);
      send_req(addr, id, line, 1'b0);
      for (int b = 0; b < 4; b++) send_beat(line[b*64 +: 64], 2'b00, b == 3);
      take_rsp();
   endtask

   initial begin
      logic [LineWidth-1:0] exp_line, la, lb;

      tv[0] = '{addr: 48'h0000_1000_0013, id: 8'h5A, line: mk(32'hD0D0_0000), resp: 8'h00, nbeats: 4, err: 1'b0};
      tv[1] = '{addr: 48'h0000_2000_003F, id: 8'h11, line: mk(32'hD0D0_0001), resp: 8'h20, nbeats: 4, err: 1'b1};
      tv[2] = '{addr: 48'h0000_2000_0040, id: 8'h22, line: mk(32'hD0D0_0002), resp: 8'h00, nbeats: 4, err: 1'b0};
      tv[3] = '{addr: 48'h0000_2000_0081, id: 8'h33, line: mk(32'hD0D0_0003), resp: 8'h03, nbeats: 4, err: 1'b1};
      tv[4] = '{addr: 48'h0000_2000_00C4, id: 8'h44, line: mk(32'hD0D0_0004), resp: 8'h00, nbeats: 2, err: 1'b1};
      tv[5] = '{addr: 48'hFFFF_FFFF_FFFF, id: 8'h55, line: mk(32'hD0D0_0005), resp: 8'h00, nbeats: 4, err: 1'b0};

      req_addr = '0;
      req_id = '0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      axi_rsp = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_ready", CW'(req_ready), CW'(1'b0));
      check("rst_rsp_valid", CW'(rsp_valid), CW'(1'b0));
      check("rst_rsp_data", rsp_data, '0);
      check("rst_rsp_error", CW'(rsp_error), CW'(1'b0));
      check("rst_rsp_id", CW'(rsp_id), CW'(8'h00));
      check("rst_busy", CW'(busy), CW'(1'b0));
      check("rst_ar_valid", CW'(axi_req.ar_valid), CW'(1'b0));
      check("rst_r_ready", CW'(axi_req.r_ready), CW'(1'b0));
      check("tieoff_aw_w_b", CW'({axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready}), CW'(3'b001));
      rst_ni = 1'b1;
      @(negedge clk);

      // Table-driven refills; early-last lines keep stale upper words
      for (int v = 0; v < 6; v++) begin
         exp_line = last_line;
         for (int b = 0; b < tv[v].nbeats; b++) exp_line[b*64 +: 64] = tv[v].line[b*64 +: 64];
         send_req(tv[v].addr, tv[v].id, exp_line, tv[v].err);
         #1;
         check("busy_after_req", CW'(busy), CW'(1'b1));
         for (int b = 0; b < tv[v].nbeats; b++)
            send_beat(tv[v].line[b*64 +: 64], tv[v].resp[2*b +: 2], b == tv[v].nbeats - 1);
         #1;
         check("rsp_latency", CW'(rsp_valid), CW'(1'b1));
         take_rsp();
      end

      // Backpressure: rsp held 5 cycles, next beat waits, then one bubble
      la = mk(32'hB0B0_0001);
      lb = mk(32'hB0B0_0002);
      send_req(48'h0000_3000_0040, 8'h61, la, 1'b0);
      send_req(48'h0000_3000_0060, 8'h62, lb, 1'b0);
      for (int b = 0; b < 4; b++) send_beat(la[b*64 +: 64], 2'b00, b == 3);
      axi_rsp.r_valid = 1'b1;
      axi_rsp.r.data = lb[63:0];
      axi_rsp.r.resp = 2'b00;
      axi_rsp.r.last = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check("bp_r_ready", CW'(axi_req.r_ready), CW'(1'b0));
         check("bp_rsp_valid", CW'(rsp_valid), CW'(1'b1));
         check("bp_rsp_data", rsp_data, la);
         check("bp_rsp_id", CW'(rsp_id), CW'(8'h61));
         @(negedge clk);
      end
      take_rsp();
      #1;
      check("bp_next_r_ready", CW'(axi_req.r_ready), CW'(1'b1));
      for (int b = 0; b < 4; b++) send_beat(lb[b*64 +: 64], 2'b00, b == 3);
      take_rsp();

      // Outstanding limit: four accepted, fifth stalls until the first pop
      for (int k = 1; k <= 4; k++)
         send_req(48'h0000_4000_0000 + 48'(k * 32), 8'(k), mk(32'h0C0C_0000 + 32'(k)), 1'b0);
      req_addr = 48'h0000_4000_00A0;
      req_id = 8'd5;
      req_valid = 1'b1;
      #1;
      check("full_req_ready", CW'(req_ready), CW'(1'b0));
      check("full_ar_valid", CW'(axi_req.ar_valid), CW'(1'b0));
      check("full_busy", CW'(busy), CW'(1'b1));
      @(negedge clk);
      la = mk(32'h0C0C_0001);
      for (int b = 0; b < 4; b++) send_beat(la[b*64 +: 64], 2'b00, b == 3);
      #1;
      check("full_at_pop_req_ready", CW'(req_ready), CW'(1'b0));
      take_rsp();
      send_req(48'h0000_4000_00A0, 8'd5, mk(32'h0C0C_0005), 1'b0);
      for (int k = 2; k <= 5; k++) begin
         la = mk(32'h0C0C_0000 + 32'(k));
         for (int b = 0; b < 4; b++) send_beat(la[b*64 +: 64], 2'b00, b == 3);
         take_rsp();
      end
      #1;
      check("idle_busy", CW'(busy), CW'(1'b0));
      @(negedge clk);

      // Reset in the middle of a burst
      la = mk(32'h7777_0000);
      send_req(48'h0000_5000_0008, 8'h77, la, 1'b0);
      send_beat(la[63:0], 2'b00, 1'b0);
      send_beat(la[127:64], 2'b00, 1'b0);
      axi_rsp.ar_ready = 1'b0;
      rst_ni = 1'b0;
      #1;
      check("mid_rst_rsp_valid", CW'(rsp_valid), CW'(1'b0));
      check("mid_rst_busy", CW'(busy), CW'(1'b0));
      check("mid_rst_r_ready", CW'(axi_req.r_ready), CW'(1'b0));
      check("mid_rst_req_ready", CW'(req_ready), CW'(1'b0));
      check("mid_rst_rsp_data", rsp_data, '0);
      sb.delete();
      last_line = '0;
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      full_line(48'h0000_5000_0020, 8'h78, mk(32'h7777_0001));

      // Missing last at the final beat: error, wrap, overwrite from beat 0
      la = mk(32'hEEEE_0001);
      lb = mk(32'hEEEE_0002);
      send_req(48'h0000_6000_0000, 8'h88, lb, 1'b1);
      for (int b = 0; b < 4; b++) send_beat(la[b*64 +: 64], 2'b00, 1'b0);
      #1;
      check("wrap_no_rsp", CW'(rsp_valid), CW'(1'b0));
      for (int b = 0; b < 4; b++) send_beat(lb[b*64 +: 64], 2'b00, b == 3);
      take_rsp();
      full_line(48'h0000_6000_0020, 8'h99, mk(32'hEEEE_0003));

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover: %0d lines outstanding, required 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/snitch_icache_axi_refill.md
Name: snitch_icache_axi_refill

Overview:
Refill initiator for the instruction cache. It takes cache-line refill requests from the cache miss path and turns each one into a single AXI4 INCR read burst. It assembles the returned R beats into a full cache line and hands the line back with the requester's ID and an error flag. It sits between the cache's refill port and the AXI master port toward L2/memory, and is the counterpart of the AXI-to-cache front end.

Parameters:
LineWidth, 256, cache line width in bits; power of two, at least AxiDataWidth.
AddrWidth, 48, refill address width.
AxiDataWidth, 64, AXI data width in bits.
IdWidth, 8, width of the opaque cache request ID returned with the line.
AxiId, 0, constant AXI ID driven on every AR.
MaxTrans, 4, maximum outstanding refill bursts (depth of the ID FIFO); at least 1.
axi_req_t, logic, AXI request struct type.
axi_rsp_t, logic, AXI response struct type.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_addr_i  in  AddrWidth  refill address; any byte inside the line
req_id_i  in  IdWidth  opaque cache ID
req_valid_i  in  1  refill request valid
req_ready_o  out  1  refill request accepted
rsp_data_o  out  LineWidth  assembled line
rsp_error_o  out  1  any beat returned SLVERR/DECERR, or a burst length violation
rsp_id_o  out  IdWidth  ID of the request this line answers
rsp_valid_o  out  1  line valid
rsp_ready_i  in  1  line consumed
axi_req_o  out  struct  AXI master request
axi_rsp_i  in  struct  AXI master response
busy_o  out  1  at least one burst outstanding

Behaviour:
- Reset (rst_ni asynchronous, active-low; clock clk_i): ID FIFO empty, beat counter 0, error flag 0, line buffer 0, state Collect.
  - Reset outputs: req_ready_o=0 (goes to ar_ready once out of reset), rsp_valid_o=0, rsp_data_o=0, rsp_error_o=0, rsp_id_o=0, busy_o=0, ar_valid=0, r_ready=0.
- Beats = LineWidth/AxiDataWidth. Counter width is max(1, log2(Beats)) bits.
- Write channels are tied off: aw_valid=0, w_valid=0, b_ready=1.
- AR path (combinational, zero latency):
  - ar_valid = req_valid_i & !fifo_full.
  - req_ready_o = ar_ready & !fifo_full.
  - ar.addr = req_addr_i with the low log2(LineWidth/8) bits cleared.
  - ar.len = Beats-1; ar.size = log2(AxiDataWidth/8); ar.burst = INCR; ar.id = AxiId; ar.cache = 4'b0010; ar.prot, qos, region, lock, user = 0.
  - On each AR handshake, req_id_i is pushed to the ID FIFO.
  - While the FIFO is full: no push and no bypass, even if a pop happens in the same cycle.
  - Responses return in order because all bursts use the single ID AxiId.
- Collect state:
  - r_ready = !fifo_empty.
  - On an R handshake: line_q[cnt*AxiDataWidth +: AxiDataWidth] = r.data; err_q |= r.resp[1]; cnt++.
  - If r.last: set err_q if cnt != Beats-1, then go to Full.
  - If cnt == Beats-1 and r.last is not set: set err_q, wrap cnt to 0 and stay in Collect, overwriting from beat 0 (protocol violation, must not hang).
- Full state:
  - rsp_valid_o=1 and r_ready=0. rsp_data_o, rsp_error_o and rsp_id_o (FIFO head) are held stable.
  - On rsp_ready_i: pop the FIFO, clear cnt and err_q, go to Collect. The next R beat can be accepted in the following cycle (one bubble per line).
- Response outputs are driven from registers; there is no combinational path from the R channel to rsp_*.
- Any R beat arriving while the FIFO is empty is not accepted (r_ready=0).
- Simultaneous AR push and response pop: both take effect; the FIFO count is unchanged.
- busy_o = !fifo_empty.
- Beats == 1: every beat completes a line; the single beat must carry r.last.

Test Plan:
- Basic refill, LineWidth=256, AxiDataWidth=64: req addr 0x1000_0013, id 0x5A -> AR addr 0x1000_0000, len 3, size 3, INCR, id 0. Beats D0..D3 with last on D3 -> rsp_data={D3,D2,D1,D0}, id 0x5A, error 0, rsp_valid one cycle after the last beat.
- Backpressure: hold rsp_ready_i low for 5 cycles after the line completes -> r_ready=0 and rsp_* stable all 5 cycles. Next burst beat D0' is accepted the cycle after the rsp handshake.
- Error: beat 2 returns resp=SLVERR -> rsp_error_o=1 and data still assembled. The following clean line reports rsp_error_o=0.
- Outstanding limit: with ar_ready=1, issue 5 requests with ids 1,2,3,4,5 -> first 4 accepted and req_ready_o=0 for the 5th until the first rsp handshake. Lines return with ids 1,2,3,4,5 in order; busy_o falls after the last.
- Early last: r.last on beat 1 -> line presented after 2 beats with rsp_error_o=1 and upper words from stale buffer. FIFO pops normally.
- Reset mid-burst: assert rst_ni low after beat 1 of 4 -> rsp_valid_o=0, busy_o=0, r_ready=0 immediately. A fresh request after reset completes normally.
